// File: rtl/floo_mcast_fork.sv
// rtl/floo_mcast_fork.sv - multicast fork: replicates one flit to every port in its route mask.
// Optional perf counters (flit/copy/stall) are built when FLOO_MCAST_FORK_PERF_EN is defined.
module floo_mcast_fork #(
  parameter int unsigned NumRoutes = 5,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  input  logic [NumRoutes-1:0] route_sel_i,
  output logic [NumRoutes-1:0] valid_o,
  input  logic [NumRoutes-1:0] ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 drop_o
`ifdef FLOO_MCAST_FORK_PERF_EN
  ,
  output logic [31:0]          flit_cnt_o,
  output logic [31:0]          copy_cnt_o,
  output logic [31:0]          stall_cnt_o
`endif
);

  typedef enum logic {
    IDLE,
    FORK
  } state_e;

  state_e               state_q, state_d;
  logic [NumRoutes-1:0] sel_q, sel_d;
  logic [NumRoutes-1:0] sent_q, sent_d;

  logic                 active;
  logic [NumRoutes-1:0] sel;
  logic [NumRoutes-1:0] hs;
  logic [NumRoutes-1:0] done;
  logic                 all_done;

  // Outputs are forced low while reset is held, even though they are combinational.
  assign active   = rst_ni & valid_i;
  assign sel      = (state_q == FORK) ? sel_q : route_sel_i;
  assign valid_o  = {NumRoutes{active}} & sel & ~sent_q;
  assign hs       = valid_o & ready_i;
  assign done     = ~sel | sent_q | hs;
  assign all_done = &done;
  assign ready_o  = active & all_done;
  assign drop_o   = active & (state_q == IDLE) & ~(|sel);
  assign data_o   = data_i;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    sent_d  = sent_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i && (|sel) && !all_done) begin
          sel_d   = route_sel_i;
          sent_d  = hs;
          state_d = FORK;
        end
      end
      FORK: begin
        // Without valid_i nothing handshakes, so the fork simply holds its progress.
        if (valid_i) begin
          if (all_done) begin
            sel_d   = '0;
            sent_d  = '0;
            state_d = IDLE;
          end else begin
            sent_d  = sent_q | hs;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      sent_q  <= sent_d;
    end
  end

`ifdef FLOO_MCAST_FORK_PERF_EN
  function automatic logic [31:0] popcount(input logic [NumRoutes-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < NumRoutes; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  logic [31:0] flit_cnt_q, flit_cnt_d;
  logic [31:0] copy_cnt_q, copy_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Dropped (empty-mask) flits have no handshakes and never enter FORK, so only flit_cnt needs the mask test.
  always_comb begin
    flit_cnt_d  = flit_cnt_q + 32'(ready_o & (|sel));
    copy_cnt_d  = copy_cnt_q + popcount(hs);
    stall_cnt_d = stall_cnt_q + 32'(state_q == FORK);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flit_cnt_q  <= '0;
      copy_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      flit_cnt_q  <= flit_cnt_d;
      copy_cnt_q  <= copy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flit_cnt_o  = flit_cnt_q;
  assign copy_cnt_o  = copy_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_floo_mcast_fork.sv
// tb/tb_floo_mcast_fork.sv - directed and randomized scoreboard bench for floo_mcast_fork.
module tb_floo_mcast_fork;

  localparam int NR = 5;
  localparam int DW = 64;

  logic          clk;
  logic          rst_n;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic [NR-1:0] route_sel_i;
  logic [NR-1:0] valid_o;
  logic [NR-1:0] ready_i;
  logic [DW-1:0] data_o;
  logic          drop_o;
`ifdef FLOO_MCAST_FORK_PERF_EN
  logic [31:0]   flit_cnt;
  logic [31:0]   copy_cnt;
  logic [31:0]   stall_cnt;
`endif

  floo_mcast_fork #(.NumRoutes(NR), .DataWidth(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .route_sel_i (route_sel_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .drop_o      (drop_o)
`ifdef FLOO_MCAST_FORK_PERF_EN
    ,
    .flit_cnt_o  (flit_cnt),
    .copy_cnt_o  (copy_cnt),
    .stall_cnt_o (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } copy_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [NR-1:0] mask;
  } flit_t;

  copy_t exp_q[$];
  flit_t cons_q[$];

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Monitor: every outstanding copy is one queue entry; a port is due a copy iff an entry names it.
  always @(negedge clk) begin
    logic [NR-1:0] pend;
    logic          exp_rdy;
    int            idx;
    if (mon_en) begin
      if (valid_i) begin
        pend = '0;
        foreach (exp_q[k]) pend[exp_q[k].port] = 1'b1;
        exp_rdy = ((pend & ~ready_i) == '0);
        chk("sb_valid_o", 64'(valid_o), 64'(pend));
        chk("sb_ready_o", 64'(ready_o), 64'(exp_rdy));
        chk("sb_drop_o", 64'(drop_o), 64'(cons_q.size() > 0 && cons_q[0].mask == '0));
        for (int i = 0; i < NR; i++) begin
          if (valid_o[i] && ready_i[i]) begin
            idx = -1;
            foreach (exp_q[k]) if (idx < 0 && exp_q[k].port == i) idx = k;
            if (idx < 0) fail_now($sformatf("sb_dup_copy port %0d got %0h expected none", i, data_o));
            else begin
              chk($sformatf("sb_copy_data p%0d", i), data_o, exp_q[idx].data);
              exp_q.delete(idx);
            end
          end
        end
        if (ready_o) begin
          if (cons_q.size() == 0) fail_now("sb_extra_consume got ready_o=1 expected 0");
          else begin
            chk("sb_consume_data", data_o, cons_q[0].data);
            void'(cons_q.pop_front());
          end
        end
      end else begin
        chk("sb_idle_valid_o", 64'(valid_o), 64'h0);
        chk("sb_idle_ready_o", 64'(ready_o), 64'h0);
        chk("sb_idle_drop_o", 64'(drop_o), 64'h0);
      end
    end
  end

  task automatic drive(input logic v, input logic [NR-1:0] sel, input logic [NR-1:0] rdy);
    valid_i     = v;
    route_sel_i = sel;
    ready_i     = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [NR-1:0] v, input logic r, input logic d);
    chk({nm, "_valid_o"}, 64'(valid_o), 64'(v));
    chk({nm, "_ready_o"}, 64'(ready_o), 64'(r));
    chk({nm, "_drop_o"}, 64'(drop_o), 64'(d));
  endtask

  function automatic int popc(input logic [NR-1:0] m);
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m[i]);
    return n;
  endfunction

  int m_flits = 0;
  int m_copies = 0;
  int m_stall = 0;

  initial begin
    logic [NR-1:0] mask;
    int            cyc;
    bit            got;
    rst_n  = 1'b0;
    data_i = 64'hdead_beef_0123_4567;
    drive(1'b1, 5'b11111, 5'b11111);
    #2;
    chk_out("reset", 5'b00000, 1'b0, 1'b0);
    next_cycle();
    rst_n = 1'b1;

    drive(1'b1, 5'b00001, 5'b11111);
    @(negedge clk);
    chk_out("unicast", 5'b00001, 1'b1, 1'b0);
    chk("unicast_data_o", data_o, 64'hdead_beef_0123_4567);
    next_cycle();

    drive(1'b1, 5'b10110, 5'b11111);
    @(negedge clk);
    chk_out("full_accept", 5'b10110, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 5'b01001, 5'b11111);
    @(negedge clk);
    chk_out("back_to_back", 5'b01001, 1'b1, 1'b0);
    next_cycle();

    drive(1'b1, 5'b10110, 5'b00010);
    @(negedge clk);
    chk_out("stagger_c0", 5'b10110, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 5'b10110, 5'b00100);
    @(negedge clk);
    chk_out("stagger_c1", 5'b10100, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 5'b10110, 5'b10000);
    @(negedge clk);
    chk_out("stagger_c2", 5'b10000, 1'b1, 1'b0);
    next_cycle();

    drive(1'b1, 5'b00000, 5'b11111);
    @(negedge clk);
    chk_out("empty_mask", 5'b00000, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 5'b00000, 5'b11111);
    @(negedge clk);
    chk_out("after_drop", 5'b00000, 1'b0, 1'b0);
    next_cycle();

    drive(1'b1, 5'b00011, 5'b00001);
    @(negedge clk);
    chk_out("mask_chg_c0", 5'b00011, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 5'b11000, 5'b00000);
    @(negedge clk);
    chk_out("mask_chg_c1", 5'b00010, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 5'b11000, 5'b11010);
    @(negedge clk);
    chk_out("mask_chg_c2", 5'b00010, 1'b1, 1'b0);
    next_cycle();

    drive(1'b1, 5'b00111, 5'b00001);
    @(negedge clk);
    chk_out("rst_fork_c0", 5'b00111, 1'b0, 1'b0);
    next_cycle();
    ready_i = 5'b00000;
    rst_n   = 1'b0;
    #1;
    chk_out("rst_fork_async", 5'b00000, 1'b0, 1'b0);
`ifdef FLOO_MCAST_FORK_PERF_EN
    chk("rst_flit_cnt", 64'(flit_cnt), 64'h0);
    chk("rst_copy_cnt", 64'(copy_cnt), 64'h0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
`endif
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("rst_fork_replay", 5'b00111, 1'b0, 1'b0);
    next_cycle();
    ready_i = 5'b11111;
    @(negedge clk);
    chk_out("rst_fork_done", 5'b00111, 1'b1, 1'b0);
    next_cycle();

    drive(1'b0, 5'b00000, 5'b00000);
    rst_n = 1'b0;
    next_cycle();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int n = 0; n < 300; n++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        drive(1'b0, NR'($urandom), NR'($urandom));
        next_cycle();
      end
      case ($urandom_range(0, 9))
        0:       mask = '0;
        1:       mask = '1;
        default: mask = NR'($urandom);
      endcase
      data_i      = {$urandom, $urandom};
      valid_i     = 1'b1;
      route_sel_i = mask;
      for (int i = 0; i < NR; i++) if (mask[i]) exp_q.push_back('{port: i, data: data_i});
      cons_q.push_back('{data: data_i, mask: mask});
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 200) begin
        ready_i = NR'($urandom);
        @(negedge clk);
        got = ready_o;
        cyc++;
        next_cycle();
        if (!got) route_sel_i = NR'($urandom);
      end
      if (!got) begin
        fail_now("timeout waiting for ready_o");
        break;
      end
      if (mask != '0) begin
        m_flits++;
        m_copies += popc(mask);
        m_stall  += cyc - 1;
      end
    end
    valid_i = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    chk("sb_copies_left", 64'(exp_q.size()), 64'h0);
    chk("sb_flits_left", 64'(cons_q.size()), 64'h0);
`ifdef FLOO_MCAST_FORK_PERF_EN
    chk("perf_flit_cnt", 64'(flit_cnt), 64'(m_flits));
    chk("perf_copy_cnt", 64'(copy_cnt), 64'(m_copies));
    chk("perf_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
